// File: rtl/spin_phase_readout_pkg.sv
`default_nettype none
// ============================================================================
// spin_phase_readout_pkg : FSM encoding and counter-width helper for readout
// Rev 1.0
// ============================================================================
package spin_phase_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bits needed to hold 0..max_val; never returns less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spin_phase_readout_sync.sv
`default_nettype none
// ============================================================================
// spin_phase_readout_sync : WIDTH-bit two-flop synchroniser, sync reset
// Rev 1.0
// ============================================================================
module spin_phase_readout_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/spin_phase_readout.sv
`default_nettype none
// ============================================================================
// spin_phase_readout : settles, samples oscillator phases against spin 0 and
// registers a majority-vote max-cut partition with a one-cycle valid pulse.
// Rev 1.0
// ============================================================================
module spin_phase_readout
  import spin_phase_readout_pkg::*;
#(
  parameter int N             = 5,
  parameter int SETTLE_CYCLES = 256,
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] spins_in,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] solution
);

  localparam int C_SW = cnt_width(SETTLE_CYCLES);
  localparam int C_MW = cnt_width(SAMPLE_CYCLES);
  localparam logic [C_SW-1:0] C_SETTLE_LAST =
      C_SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [C_MW-1:0] C_SAMPLE_LAST = C_MW'(SAMPLE_CYCLES - 1);
  localparam logic [C_MW-1:0] C_HALF        = C_MW'(SAMPLE_CYCLES / 2);

  logic [N-1:0]    w_sync;
  logic [N-1:0]    w_next_sol;
  state_t          r_state;
  logic [C_SW-1:0] r_settle_cnt;
  logic [C_MW-1:0] r_sample_cnt;
  logic [C_MW-1:0] r_mis_cnt [1:N-1];

  spin_phase_readout_sync #(
    .WIDTH (N)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (spins_in),
    .q   (w_sync)
  );

  // Strictly greater than half: an exact tie stays in spin 0's partition.
  always_comb begin
    w_next_sol = '0;
    for (int i = 1; i < N; i++) begin
      w_next_sol[i] = (r_mis_cnt[i] > C_HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      busy         <= 1'b0;
      valid        <= 1'b0;
      solution     <= '0;
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      for (int i = 1; i < N; i++) begin
        r_mis_cnt[i] <= '0;
      end
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            for (int i = 1; i < N; i++) begin
              r_mis_cnt[i] <= '0;
            end
            r_state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          if (r_settle_cnt == C_SETTLE_LAST) begin
            r_sample_cnt <= '0;
            for (int i = 1; i < N; i++) begin
              r_mis_cnt[i] <= '0;
            end
            r_state <= SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + C_SW'(1);
          end
        end
        SAMPLE: begin
          for (int i = 1; i < N; i++) begin
            r_mis_cnt[i] <= r_mis_cnt[i] + C_MW'(w_sync[i] ^ w_sync[0]);
          end
          if (r_sample_cnt == C_SAMPLE_LAST) begin
            r_state <= DONE;
          end else begin
            r_sample_cnt <= r_sample_cnt + C_MW'(1);
          end
        end
        DONE: begin
          solution <= w_next_sol;
          valid    <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
